// File: rtl/cat_if_pkg.sv
// Shared definitions for the AD9361 (Catalina) SISO sample-bus emulator:
// source-mode encodings, default widths and the I/Q slot encoding.
package cat_if_pkg;

    localparam int DEF_WIDTH = 12;
    localparam int DEF_CNT_W = 16;

    localparam logic [1:0] MODE_STREAM = 2'd0;
    localparam logic [1:0] MODE_RAMP   = 2'd1;
    localparam logic [1:0] MODE_ZERO   = 2'd2;

    // Bus phase: the I word travels with frame high, the Q word with frame low.
    typedef enum logic {
        I_SLOT = 1'b0,
        Q_SLOT = 1'b1
    } slot_t;

endpackage

// File: rtl/cat_bus_deframer.sv
// Deframes the FPGA-to-Catalina SISO stream back into I/Q pairs, tracks
// alignment lock and counts framing violations.
module cat_bus_deframer
    import cat_if_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int LOCK_PAIRS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tx_frame,
    input  logic [WIDTH-1:0] tx_data,
    output logic [WIDTH-1:0] m_i,
    output logic [WIDTH-1:0] m_q,
    output logic             m_valid,
    output logic             locked,
    output logic [CNT_W-1:0] frame_err_cnt
);

    localparam int RUN_W = $clog2(LOCK_PAIRS + 1);

    logic             prev_valid;
    logic             prev_frame;
    logic [WIDTH-1:0] prev_data;
    logic [RUN_W-1:0] good_run;
    logic             pair_good;
    logic             frame_viol;

    // prev_valid masks the first cycle after reset, which has no history.
    assign pair_good  = prev_valid && prev_frame && !tx_frame;
    assign frame_viol = prev_valid && (prev_frame == tx_frame);

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_valid    <= 1'b0;
            prev_frame    <= 1'b0;
            prev_data     <= '0;
            m_i           <= '0;
            m_q           <= '0;
            m_valid       <= 1'b0;
            locked        <= 1'b0;
            good_run      <= '0;
            frame_err_cnt <= '0;
        end else begin
            prev_valid <= 1'b1;
            prev_frame <= tx_frame;
            prev_data  <= tx_data;
            m_valid    <= pair_good;

            if (pair_good) begin
                m_i <= prev_data;
                m_q <= tx_data;
                if (good_run != RUN_W'(LOCK_PAIRS)) begin
                    good_run <= good_run + RUN_W'(1);
                end
                if (good_run == RUN_W'(LOCK_PAIRS - 1)) begin
                    locked <= 1'b1;
                end
            end

            if (frame_viol) begin
                good_run <= '0;
                locked   <= 1'b0;
                if (frame_err_cnt != '1) begin
                    frame_err_cnt <= frame_err_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/cat_bus_emulator.sv
// Catalina end of the 12-bit SISO sample bus: I/Q source toward the FPGA
// (stream, ramp or zero) plus the deframer for the returning stream.
module cat_bus_emulator
    import cat_if_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int LOCK_PAIRS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] s_i,
    input  logic [WIDTH-1:0] s_q,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             rx_frame,
    output logic [WIDTH-1:0] rx_data,
    input  logic             tx_frame,
    input  logic [WIDTH-1:0] tx_data,
    output logic [WIDTH-1:0] m_i,
    output logic [WIDTH-1:0] m_q,
    output logic             m_valid,
    output logic             locked,
    output logic [CNT_W-1:0] underflow_cnt,
    output logic [CNT_W-1:0] frame_err_cnt
);

    slot_t            phase;
    slot_t            phase_nxt;
    logic             frame_nxt;
    logic [WIDTH-1:0] data_nxt;
    logic [WIDTH-1:0] q_hold;
    logic [WIDTH-1:0] q_hold_nxt;
    logic [WIDTH-1:0] ramp;
    logic [WIDTH-1:0] ramp_nxt;
    logic [CNT_W-1:0] underflow_nxt;

    // Stream handshake: a sample transfers on an edge where s_valid and
    // s_ready are both high. s_ready does not depend on s_valid and is high
    // only in I_SLOT of stream mode; the bus never stalls, so an I_SLOT
    // without s_valid sends zeros and counts an underflow.
    assign s_ready = (phase == I_SLOT) && (mode == MODE_STREAM) && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            phase         <= I_SLOT;
            rx_frame      <= 1'b0;
            rx_data       <= '0;
            q_hold        <= '0;
            ramp          <= '0;
            underflow_cnt <= '0;
        end else begin
            phase         <= phase_nxt;
            rx_frame      <= frame_nxt;
            rx_data       <= data_nxt;
            q_hold        <= q_hold_nxt;
            ramp          <= ramp_nxt;
            underflow_cnt <= underflow_nxt;
        end
    end

    // Mode is looked at only in I_SLOT so both words of a pair share a source.
    always_comb begin
        phase_nxt     = (phase == I_SLOT) ? Q_SLOT : I_SLOT;
        frame_nxt     = 1'b0;
        data_nxt      = q_hold;
        q_hold_nxt    = q_hold;
        ramp_nxt      = ramp;
        underflow_nxt = underflow_cnt;

        if (phase == I_SLOT) begin
            frame_nxt  = 1'b1;
            data_nxt   = '0;
            q_hold_nxt = '0;
            case (mode)
                MODE_STREAM: begin
                    if (s_valid) begin
                        data_nxt   = s_i;
                        q_hold_nxt = s_q;
                    end else if (underflow_cnt != '1) begin
                        underflow_nxt = underflow_cnt + CNT_W'(1);
                    end
                end
                MODE_RAMP: begin
                    data_nxt   = ramp;
                    q_hold_nxt = ~ramp;
                    ramp_nxt   = ramp + WIDTH'(1);
                end
                default: begin
                    data_nxt   = '0;
                    q_hold_nxt = '0;
                end
            endcase
        end
    end

    cat_bus_deframer #(
        .WIDTH      (WIDTH),
        .CNT_W      (CNT_W),
        .LOCK_PAIRS (LOCK_PAIRS)
    ) u_deframer (
        .clk           (clk),
        .reset         (reset),
        .tx_frame      (tx_frame),
        .tx_data       (tx_data),
        .m_i           (m_i),
        .m_q           (m_q),
        .m_valid       (m_valid),
        .locked        (locked),
        .frame_err_cnt (frame_err_cnt)
    );

endmodule
